// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  // Injected no-op: SPECIAL opcode with funct 6'b000001, ignored by decode.
  localparam logic [31:0] BUBBLE_INST = 32'h0000_0001;

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    RUN    = 3'd1,
    BUBBLE = 3'd2,
    WAIT   = 3'd3,
    HALT   = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch.sv
// Instruction fetch: owns the PC, drives a 1-cycle synchronous BRAM, feeds (pc, inst) to decode.
// Latency: the BRAM address follows dec_npc combinationally, so the next inst is presented the following cycle.
// Backpressure: decode stalls fetch via dec_hazard (one bubble + replay), dec_wait_time (bubbles + replay) and dec_stop (halt).
module fetch
  import fetch_pkg::*;
#(
  parameter int unsigned IMEM_AW  = 14,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] BUBBLE_I = BUBBLE_INST
) (
  input  logic               clk,
  input  logic               rstn,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic [31:0]        dec_npc,
  input  logic               dec_hazard,
  input  logic [4:0]         dec_wait_time,
  input  logic               dec_stop,
  output logic [31:0]        pc,
  output logic [31:0]        inst,
  output logic               valid,
  output logic               halted
);

  fetch_state_t       state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [31:0]        hold_q, hold_d;
  logic               replay_q, replay_d;
  logic [4:0]         wait_cnt_q, wait_cnt_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic               halted_q, halted_d;

  logic [IMEM_AW-1:0] npc_addr;
  logic [31:0]        run_inst;

  // Word address of decode's next PC; low byte bits dropped, high bits alias.
  assign npc_addr = dec_npc[IMEM_AW+1:2];

  // In RUN the presented inst is either fresh BRAM data or the held copy being replayed.
  assign run_inst = replay_q ? hold_q : imem_rdata;

  assign pc     = pc_q;
  assign halted = halted_q;

  // State register and all datapath registers; reset discards any hold/wait context.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      hold_q     <= BUBBLE_I;
      replay_q   <= 1'b0;
      wait_cnt_q <= 5'd0;
      addr_q     <= RESET_PC[IMEM_AW+1:2];
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      hold_q     <= hold_d;
      replay_q   <= replay_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      halted_q   <= halted_d;
    end
  end

  // Next-state, PC steering and output mux; decode inputs only matter while a real inst is shown.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    replay_d   = replay_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    halted_d   = halted_q;
    imem_addr  = addr_q;
    inst       = BUBBLE_I;
    valid      = 1'b0;

    case (state_q)
      BOOT: begin
        // BRAM is reading RESET_PC this cycle; its data is usable next cycle.
        replay_d = 1'b0;
        state_d  = RUN;
      end

      RUN: begin
        inst     = run_inst;
        valid    = 1'b1;
        replay_d = 1'b0;
        if (dec_stop) begin
          // Address stays frozen on the halt op; nothing further is fetched.
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (dec_hazard) begin
          // Keep the branch and its PC; it is shown again after one bubble.
          hold_d  = run_inst;
          state_d = BUBBLE;
        end else begin
          // Fetch the resolved target directly: no delay slot, nothing to flush.
          pc_d      = dec_npc;
          imem_addr = npc_addr;
          addr_d    = npc_addr;
          if (dec_wait_time > 5'd1) begin
            wait_cnt_d = dec_wait_time - 5'd1;
            state_d    = WAIT;
          end
        end
      end

      BUBBLE: begin
        state_d  = RUN;
        replay_d = 1'b1;
      end

      WAIT: begin
        // Address is held, so the BRAM keeps returning the already-fetched inst.
        hold_d     = imem_rdata;
        wait_cnt_d = wait_cnt_q - 5'd1;
        if (wait_cnt_q <= 5'd1) begin
          wait_cnt_d = 5'd0;
          state_d    = RUN;
          replay_d   = 1'b1;
        end
      end

      HALT: begin
        halted_d = 1'b1;
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: BRAM model plus hand-driven decode responses.
// Latency: BRAM model returns data one clock after the address.
// Backpressure: decode hazard/wait/stop driven explicitly per step.
module tb_fetch;
  import fetch_pkg::*;

  localparam int AW = 14;
  localparam logic [31:0] BUB = 32'h0000_0001;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic [31:0]   dec_npc;
  logic          dec_hazard;
  logic [4:0]    dec_wait_time;
  logic          dec_stop;
  logic [31:0]   pc;
  logic [31:0]   inst;
  logic          valid;
  logic          halted;

  logic [31:0] mem [0:(1<<AW)-1];

  int total  = 0;
  int passed = 0;

  fetch #(.IMEM_AW(AW), .RESET_PC(32'h0), .BUBBLE_I(BUB)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .dec_npc       (dec_npc),
    .dec_hazard    (dec_hazard),
    .dec_wait_time (dec_wait_time),
    .dec_stop      (dec_stop),
    .pc            (pc),
    .inst          (inst),
    .valid         (valid),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Synchronous BRAM, one cycle read latency.
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [31:0] npc, input logic hz, input logic [4:0] wt, input logic st);
    dec_npc       = npc;
    dec_hazard    = hz;
    dec_wait_time = wt;
    dec_stop      = st;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string tag, input logic [31:0] epc, input logic [31:0] einst, input logic evalid);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".inst"}, inst, einst);
    chk({tag, ".valid"}, {31'd0, valid}, {31'd0, evalid});
  endtask

  task automatic chk_addr(input string tag, input logic [31:0] exp);
    #1;
    chk({tag, ".imem_addr"}, {{(32-AW){1'b0}}, imem_addr}, exp);
  endtask

  initial begin
    // Each word tagged with its own word index so any wrong fetch is visible.
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hC000_0000 | 32'(i);

    // Reset state.
    rstn = 1'b0;
    drive(32'h0, 1'b0, 5'd1, 1'b0);
    #2;
    out("reset", 32'h0, BUB, 1'b0);
    chk("reset.halted", {31'd0, halted}, 32'd0);
    chk_addr("reset", 32'h0);

    // BOOT cycle after release: still a bubble.
    #5 rstn = 1'b1;
    #1;
    out("boot", 32'h0, BUB, 1'b0);
    step();

    // Straight-line fetch: pc 0, then lw at pc 4 with wait_time 3.
    out("run0", 32'h0, 32'hC000_0000, 1'b1);
    drive(32'h4, 1'b0, 5'd1, 1'b0);
    chk_addr("run0", 32'h1);
    step();
    out("lw", 32'h4, 32'hC000_0001, 1'b1);
    drive(32'h8, 1'b0, 5'd3, 1'b0);
    chk_addr("lw", 32'h2);
    step();

    // Two wait bubbles; decode inputs are noise and must be ignored.
    out("wait1", 32'h8, BUB, 1'b0);
    drive(32'h800, 1'b1, 5'd7, 1'b1);
    chk_addr("wait1", 32'h2);
    step();
    out("wait2", 32'h8, BUB, 1'b0);
    chk("wait2.halted", {31'd0, halted}, 32'd0);
    step();

    // Inst from pc 8 (beq) with hazard raised for one cycle.
    out("beq", 32'h8, 32'hC000_0002, 1'b1);
    drive(32'h40, 1'b1, 5'd1, 1'b0);
    chk_addr("beq", 32'h2);
    step();
    out("hz_bub", 32'h8, BUB, 1'b0);
    drive(32'h800, 1'b1, 5'd7, 1'b1);
    chk_addr("hz_bub", 32'h2);
    step();
    out("replay", 32'h8, 32'hC000_0002, 1'b1);
    drive(32'h40, 1'b0, 5'd1, 1'b0);
    chk_addr("replay", 32'h10);
    step();

    // Branch target, then jal to 0x100, then jump to the halt op at 0x10.
    out("target", 32'h40, 32'hC000_0010, 1'b1);
    drive(32'h100, 1'b0, 5'd1, 1'b0);
    chk_addr("jal", 32'h40);
    step();
    out("jal_tgt", 32'h100, 32'hC000_0040, 1'b1);
    drive(32'h10, 1'b0, 5'd1, 1'b0);
    step();
    out("halt_op", 32'h10, 32'hC000_0004, 1'b1);
    chk("halt_op.halted", {31'd0, halted}, 32'd0);
    drive(32'h14, 1'b0, 5'd1, 1'b1);
    chk_addr("halt_op", 32'h4);
    step();

    // Halted: absorbing regardless of decode inputs, address frozen.
    for (int k = 0; k < 3; k++) begin
      out("halted", 32'h10, BUB, 1'b0);
      chk("halted.flag", {31'd0, halted}, 32'd1);
      drive(32'h200 + 32'(k * 4), k[0], 5'd3, 1'b0);
      chk_addr("halted", 32'h4);
      step();
    end

    // Reset out of HALT, restart, then reset mid-WAIT.
    rstn = 1'b0;
    #1;
    chk("rst_halt.halted", {31'd0, halted}, 32'd0);
    out("rst_halt", 32'h0, BUB, 1'b0);
    #1 rstn = 1'b1;
    drive(32'h0, 1'b0, 5'd1, 1'b0);
    step();
    out("restart0", 32'h0, 32'hC000_0000, 1'b1);
    drive(32'h4, 1'b0, 5'd5, 1'b0);
    step();
    out("w5_1", 32'h4, BUB, 1'b0);
    step();
    chk("w5_2.valid", {31'd0, valid}, 32'd0);
    #3 rstn = 1'b0;
    #1;
    out("rst_wait", 32'h0, BUB, 1'b0);
    chk("rst_wait.halted", {31'd0, halted}, 32'd0);
    chk_addr("rst_wait", 32'h0);
    rstn = 1'b1;
    drive(32'h0, 1'b0, 5'd1, 1'b0);
    step();
    out("clean0", 32'h0, 32'hC000_0000, 1'b1);
    drive(32'h4, 1'b0, 5'd1, 1'b0);
    step();
    out("clean4", 32'h4, 32'hC000_0001, 1'b1);

    // Address aliasing above IMEM_AW+1, then wrap at the top of PC space with wait_time 0.
    drive(32'h0001_0008, 1'b0, 5'd1, 1'b0);
    chk_addr("alias", 32'h2);
    step();
    out("alias", 32'h0001_0008, 32'hC000_0002, 1'b1);
    drive(32'hFFFF_FFFC, 1'b0, 5'd0, 1'b0);
    chk_addr("top", 32'h3FFF);
    step();
    out("top", 32'hFFFF_FFFC, 32'hC000_3FFF, 1'b1);
    drive(32'h0, 1'b0, 5'd1, 1'b0);
    step();
    out("wrap", 32'h0, 32'hC000_0000, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
